led_matrix_renderer: RTL and testbench
======================================

# led_matrix_renderer

Module `led` is the Pong frame renderer. It converts game state into a registered 64×64 LED bitmap and sits between the game-logic core and the LED panel driver. Game state is ball position, two paddle positions and two 3-bit scores. Each frame is rebuilt combinationally from the inputs and captured on every clock edge.

## Interface
Parameters: none. All dimensions are fixed constants in `led_pkg`.
- `clk` input 1: single system clock; all state is in this domain.
- `rst` input 1: asynchronous, active-high reset.
- `bx` input 6: ball column, 0..63.
- `by` input 6: ball row, 0..63.
- `p1y` input 6: top row of player-1 (left) paddle.
- `p2y` input 6: top row of player-2 (right) paddle.
- `sc1` input 3: player-1 score, 0..7.
- `sc2` input 3: player-2 score, 0..7.
- `matrix` output [63:0][0:63]: `matrix[r][c]`, r = row with 0 at top, c = column with 0 at left. Column 0 is the MSB of each row word; 1 = LED on.

## Operation
- The frame is the bitwise OR of all layers. Pixels outside 0..63 are clipped. Nothing wraps.
- Ball layer: 2×2 square at rows by..by+1, cols bx..bx+1.
- Paddle 1 layer: col 1, rows p1y..p1y+7 (height 8).
- Paddle 2 layer: col 62, rows p2y..p2y+7.
- Score layer: 3×5 glyphs at rows 1..5.
  - sc1 glyph occupies cols 26..28.
  - sc2 glyph occupies cols 35..37.
  - Glyph rows are listed top to bottom; the leftmost bit maps to the lowest column.
  - 0=111,101,101,101,111
  - 1=010,110,010,010,111
  - 2=111,001,111,100,111
  - 3=111,001,111,001,111
  - 4=101,101,111,001,001
  - 5=111,100,111,001,111
  - 6=111,100,111,101,111
  - 7=111,001,001,001,001
- All other pixels are 0.
- Overlapping layers simply OR together. No layer has priority.
- Inputs are treated as unsigned. The paddle end-row is computed in 7 bits so that, for example, p1y=60 lights rows 60..63 only.

## Timing
- `rst` asserted: `matrix` clears to all zeros immediately, with no dependence on `clk`. It holds zero while `rst` is high.
- First rising edge of `clk` after `rst` deasserts: `matrix` loads the frame for the inputs present at that edge.
- Latency is 1 cycle, input to output. The output reflects the inputs sampled at the most recent rising edge.
- No handshake is used. A new frame is produced every cycle.
- Input changes between edges have no effect on `matrix` until the next edge.
- If reset asserts mid-operation, the frame is discarded. The next frame after release is computed fresh.

## Configuration
- `LED_CENTER_NET_EN` defined: a dashed net is ORed into cols 31 and 32 on every row where (row mod 4) < 2. That is rows 0,1,4,5,…,60,61.
- `LED_CENTER_NET_EN` undefined: no net is drawn, and cols 31/32 are lit only by other layers. The ball is the only layer that can reach them.

## Structure
- `led_pkg` holds all shared constants:
  - `ROWS`/`COLS` = 64
  - `PADDLE_H` = 8
  - `P1_COL` = 1, `P2_COL` = 62
  - `BALL_SZ` = 2
  - `SCORE_ROW` = 1, `SC1_COL` = 26, `SC2_COL` = 35
  - the packed matrix typedef
- Sub-module `led_digit_font`: combinational ROM mapping a 3-bit digit to a 15-bit glyph (5 rows × 3 bits). It is instantiated twice, once per score.
- The top level holds the layer compositing logic and the output register.

## Test plan
- Reset: hold `rst`=1 with arbitrary inputs → every row of `matrix` = 0, including before any `clk` edge.
- Nominal frame: bx=20, by=20, p1y=20, p2y=20, sc1=2, sc2=1, then one edge. Required result, with everything else 0 (net off):
  - rows 20..27 have col 1 and col 62 set;
  - rows 20,21 also have cols 20,21 set;
  - rows 1..5 show glyph "2" at cols 26..28 and glyph "1" at cols 35..37.
- Clipping: bx=63, by=63, p1y=60, p2y=63 → only (63,63) is lit for the ball; col 1 rows 60..63 only; col 62 row 63 only.
- Latency: change bx from 10 to 40 mid-cycle → `matrix` still shows the ball at col 10 until the next rising edge, then col 40.
- Scores: sweep sc1 and sc2 over 0..7 → rows 1..5 match the glyph table exactly.
- Net macro: build with `LED_CENTER_NET_EN`, all other layers placed away from center → cols 31/32 set on rows 0,1,4,5,…,61 and clear on rows 2,3,6,7,…,63.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the Pong LED frame renderer.
// Geometry is fixed for a 64x64 panel.
package led_pkg;

  localparam int ROWS      = 64;
  localparam int COLS      = 64;
  localparam int PADDLE_H  = 8;
  localparam int P1_COL    = 1;
  localparam int P2_COL    = 62;
  localparam int BALL_SZ   = 2;
  localparam int SCORE_ROW = 1;
  localparam int SC1_COL   = 26;
  localparam int SC2_COL   = 35;
  localparam int GLYPH_W   = 3;
  localparam int GLYPH_H   = 5;
  localparam int NET_COL_L = 31;
  localparam int NET_COL_R = 32;

  // Row r is word r; column 0 is the MSB of each row word.
  typedef logic [ROWS-1:0][0:COLS-1] matrix_t;
  typedef logic [GLYPH_W*GLYPH_H-1:0] glyph_t;

  // 7-bit sum so anything past the panel edge shows up in bit 6 and is clipped.
  function automatic logic [6:0] span(input logic [5:0] base, input int off);
    return {1'b0, base} + 7'(off);
  endfunction

endpackage

// File: rtl/led_if.sv
// Game-state bus from the game-logic core into the frame renderer.
interface led_if;
  logic [5:0] bx;
  logic [5:0] by;
  logic [5:0] p1y;
  logic [5:0] p2y;
  logic [2:0] sc1;
  logic [2:0] sc2;

  modport master (output bx, by, p1y, p2y, sc1, sc2);
  modport slave  (input  bx, by, p1y, p2y, sc1, sc2);
endinterface

// File: rtl/led_digit_font.sv
// 3x5 digit font ROM; row 0 sits in the top three bits, leftmost pixel is the
// MSB of each triple.
module led_digit_font
  import led_pkg::*;
(
  input  logic [2:0] digit,
  output glyph_t     glyph
);

  always_comb begin
    case (digit)
      3'd0:    glyph = 15'b111_101_101_101_111;
      3'd1:    glyph = 15'b010_110_010_010_111;
      3'd2:    glyph = 15'b111_001_111_100_111;
      3'd3:    glyph = 15'b111_001_111_001_111;
      3'd4:    glyph = 15'b101_101_111_001_001;
      3'd5:    glyph = 15'b111_100_111_001_111;
      3'd6:    glyph = 15'b111_100_111_101_111;
      default: glyph = 15'b111_001_001_001_001;
    endcase
  end

endmodule

// File: rtl/led_matrix_renderer.sv
// Pong frame renderer: ORs ball, paddles, score glyphs (and optionally a
// dashed centre net, macro LED_CENTER_NET_EN) into a registered 64x64 bitmap.
module led_matrix_renderer
  import led_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  led_if.slave        bus,
  output matrix_t     matrix
);

  matrix_t    frame;
  glyph_t     glyph1;
  glyph_t     glyph2;
  logic [6:0] r7;
  logic [6:0] c7;

  led_digit_font u_font1 (.digit(bus.sc1), .glyph(glyph1));
  led_digit_font u_font2 (.digit(bus.sc2), .glyph(glyph2));

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    frame = '0;
    r7    = '0;
    c7    = '0;

    for (int dr = 0; dr < BALL_SZ; dr++) begin
      for (int dc = 0; dc < BALL_SZ; dc++) begin
        r7 = span(bus.by, dr);
        c7 = span(bus.bx, dc);
        if (!r7[6] && !c7[6]) frame[r7[5:0]][c7[5:0]] = 1'b1;
      end
    end

    for (int i = 0; i < PADDLE_H; i++) begin
      r7 = span(bus.p1y, i);
      if (!r7[6]) frame[r7[5:0]][P1_COL] = 1'b1;
      r7 = span(bus.p2y, i);
      if (!r7[6]) frame[r7[5:0]][P2_COL] = 1'b1;
    end

    // Glyph bit (GLYPH_W*GLYPH_H-1) is the top-left pixel.
    for (int gr = 0; gr < GLYPH_H; gr++) begin
      for (int gc = 0; gc < GLYPH_W; gc++) begin
        frame[SCORE_ROW+gr][SC1_COL+gc] = frame[SCORE_ROW+gr][SC1_COL+gc]
                                        | glyph1[GLYPH_W*GLYPH_H-1-(gr*GLYPH_W+gc)];
        frame[SCORE_ROW+gr][SC2_COL+gc] = frame[SCORE_ROW+gr][SC2_COL+gc]
                                        | glyph2[GLYPH_W*GLYPH_H-1-(gr*GLYPH_W+gc)];
      end
    end

`ifdef LED_CENTER_NET_EN
    for (int r = 0; r < ROWS; r++) begin
      if ((r % 4) < 2) begin
        frame[r][NET_COL_L] = 1'b1;
        frame[r][NET_COL_R] = 1'b1;
      end
    end
`else
    // No net: centre columns are reachable by the ball alone.
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) matrix <= '0;
    else     matrix <= frame;
  end

endmodule

// File: tb/tb_led_matrix_renderer.sv
// Self-checking bench for led_matrix_renderer against a pixel-rule reference model.
module tb_led_matrix_renderer;
  import led_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  matrix_t matrix;
  led_if   bus ();

  int checks = 0;
  int errors = 0;

  int cur_bx, cur_by, cur_p1y, cur_p2y, cur_sc1, cur_sc2;

  logic [2:0] font [8][5] = '{
    '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
    '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
    '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
    '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
    '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001}
  };

  led_matrix_renderer dut (.clk(clk), .rst(rst), .bus(bus.slave), .matrix(matrix));

  always #5 clk = ~clk;

  function automatic bit glyph_px(int digit, int r, int c, int base);
    logic [2:0] bits;
    if (r < 1 || r > 5 || c < base || c > base + 2) return 1'b0;
    bits = font[digit][r-1];
    return bits[2-(c-base)];
  endfunction

  function automatic matrix_t model(int bx, int by, int p1y, int p2y, int sc1, int sc2);
    matrix_t m;
    bit on;
    m = '0;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        on = (r >= by && r <= by + 1 && c >= bx && c <= bx + 1)
          || (c == 1  && r >= p1y && r < p1y + 8)
          || (c == 62 && r >= p2y && r < p2y + 8)
          || glyph_px(sc1, r, c, 26)
          || glyph_px(sc2, r, c, 35);
`ifdef LED_CENTER_NET_EN
        if ((c == 31 || c == 32) && (r % 4) < 2) on = 1'b1;
`endif
        m[r][c] = on;
      end
    end
    return m;
  endfunction

  task automatic check_frame(input string tag, input matrix_t exp);
    for (int r = 0; r < 64; r++) begin
      checks++;
      assert (matrix[r] === exp[r]) else begin
        errors++;
        $error("FAIL %s row %0d observed %h expected %h", tag, r, matrix[r], exp[r]);
      end
    end
  endtask

  task automatic drive(input int bx, input int by, input int p1y, input int p2y,
                       input int sc1, input int sc2);
    cur_bx = bx; cur_by = by; cur_p1y = p1y; cur_p2y = p2y; cur_sc1 = sc1; cur_sc2 = sc2;
    bus.bx  = 6'(bx);
    bus.by  = 6'(by);
    bus.p1y = 6'(p1y);
    bus.p2y = 6'(p2y);
    bus.sc1 = 3'(sc1);
    bus.sc2 = 3'(sc2);
  endtask

  task automatic drive_random();
    drive(int'($urandom_range(63)), int'($urandom_range(63)), int'($urandom_range(63)),
          int'($urandom_range(63)), int'($urandom_range(7)), int'($urandom_range(7)));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_frame(tag, model(cur_bx, cur_by, cur_p1y, cur_p2y, cur_sc1, cur_sc2));
  endtask

  initial begin
    matrix_t frozen;
    rst = 1'b0;
    drive_random();
    #1 rst = 1'b1;
    #1 check_frame("reset_async", '0);
    repeat (3) @(negedge clk);
    check_frame("reset_hold", '0);

    drive(20, 20, 20, 20, 2, 1);
    rst = 1'b0;
    step("nominal");
`ifndef LED_CENTER_NET_EN
    checks++;
    assert (matrix[20] === 64'h4000_0C00_0000_0002) else begin
      errors++;
      $error("FAIL nominal_row20 observed %h expected %h", matrix[20], 64'h4000_0C00_0000_0002);
    end
    checks++;
    assert (matrix[1] === 64'h0000_0038_0800_0000) else begin
      errors++;
      $error("FAIL nominal_row1 observed %h expected %h", matrix[1], 64'h0000_0038_0800_0000);
    end
`endif

    drive(63, 63, 60, 63, 0, 0);
    step("clip_corner");
    drive(62, 0, 56, 57, 7, 7);
    step("clip_edges");

    drive(10, 30, 40, 40, 3, 4);
    step("latency_before");
    frozen = model(10, 30, 40, 40, 3, 4);
    #1 drive(40, 30, 40, 40, 3, 4);
    #1 check_frame("latency_hold", frozen);
    @(negedge clk);
    check_frame("latency_after", model(40, 30, 40, 40, 3, 4));

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        drive(50, 50, 40, 40, a, b);
        step("score_sweep");
      end
    end

`ifdef LED_CENTER_NET_EN
    drive(5, 40, 30, 30, 0, 0);
    step("net_only");
`endif

    for (int i = 0; i < 150; i++) begin
      drive_random();
      step("random");
    end

    drive_random();
    #2 rst = 1'b1;
    #1 check_frame("reset_mid", '0);
    @(negedge clk);
    check_frame("reset_mid_hold", '0);
    drive_random();
    rst = 1'b0;
    step("after_reset");

    for (int i = 0; i < 20; i++) begin
      drive_random();
      step("random_tail");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
